// File: rtl/demod_pkg.sv
// Types and constants shared by the demodulation front end.
// Used by the ADC scheduler and its FM decimator.
package demod_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SOC      = 2'd1,
    WAIT_EOC = 2'd2,
    CAPTURE  = 2'd3
  } fsm_state_e;

  localparam logic CH_FM = 1'b0;
  localparam logic CH_AM = 1'b1;

  // Bits needed to hold 0..max_val without wrapping; never less than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sample_decimator.sv
// Decimates a sample-valid stream by BPS_PARA into a 1-cycle strobe that is
// coincident with the registered valid of the sample that completes the group.
module sample_decimator
  import demod_pkg::*;
#(
  parameter int BPS_PARA = 10
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic enable_i,
  input  logic sample_valid_i,
  output logic strobe_o
);

  localparam int               DEC_W    = cnt_w(BPS_PARA - 1);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(BPS_PARA - 1);

  logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;
  logic             strobe_q, strobe_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    dec_cnt_d = dec_cnt_q;
    strobe_d  = 1'b0;
    if (!enable_i) begin
      dec_cnt_d = '0;
    end else if (sample_valid_i) begin
      if (dec_cnt_q == DEC_LAST) begin
        dec_cnt_d = '0;
        strobe_d  = 1'b1;
      end else begin
        dec_cnt_d = dec_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      dec_cnt_q <= '0;
      strobe_q  <= 1'b0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
      strobe_q  <= strobe_d;
    end
  end

  assign strobe_o = strobe_q;

endmodule

// File: rtl/adc_sample_scheduler.sv
// Shared-ADC scheduler: slot timer, FM/AM round-robin arbiter, conversion FSM
// with EOC timeout, result routing and FM audio-rate strobe generation.
module adc_sample_scheduler
  import demod_pkg::*;
#(
  parameter int SLOT_CYC    = 250,
  parameter int BPS_PARA    = 10,
  parameter int DATA_W      = 12,
  parameter int TIMEOUT_CYC = 200
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              FM_demod_en,
  input  logic              AM_demod_en,
  input  logic              ADC_EOC,
  input  logic [DATA_W-1:0] ADC_DATA,
  output logic              ADC_SOC,
  output logic              ADC_CH,
  output logic              fm_sample_valid,
  output logic [DATA_W-1:0] fm_sample_data,
  output logic              am_sample_valid,
  output logic [DATA_W-1:0] am_sample_data,
  output logic              clk_fm_demo_sampling,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int                SLOT_W    = cnt_w(SLOT_CYC - 1);
  localparam int                TO_W      = cnt_w(TIMEOUT_CYC - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYC - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  fsm_state_e        state_q;
  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_inc;
  logic              eoc_q, last_ch_q, ch_q, soc_q;
  logic              fm_valid_q, am_valid_q, overrun_q, timeout_q;
  logic [DATA_W-1:0] fm_data_q, am_data_q;
  logic              any_en, slot_tick, eoc_rise, grant, fm_take, am_take;

  assign any_en     = FM_demod_en | AM_demod_en;
  assign slot_tick  = any_en && (slot_cnt_q == SLOT_LAST);
  assign eoc_rise   = ADC_EOC & ~eoc_q;
  assign to_cnt_inc = to_cnt_q + 1'b1;

  // A result is delivered only if its owner is still enabled when it lands.
  assign fm_take = (state_q == WAIT_EOC) && eoc_rise && (ch_q == CH_FM) && FM_demod_en;
  assign am_take = (state_q == WAIT_EOC) && eoc_rise && (ch_q == CH_AM) && AM_demod_en;

  always_comb begin
    if (FM_demod_en && AM_demod_en) grant = ~last_ch_q;
    else if (FM_demod_en)           grant = CH_FM;
    else                            grant = CH_AM;
  end

  always_comb begin
    slot_cnt_d = slot_cnt_q + 1'b1;
    if (!any_en || slot_cnt_q == SLOT_LAST) slot_cnt_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      slot_cnt_q <= '0;
      eoc_q      <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      eoc_q      <= ADC_EOC;
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: result registers are reset too, because they are visible outputs that must read 0.
    if (!RSTn) begin
      state_q    <= IDLE;
      to_cnt_q   <= '0;
      last_ch_q  <= CH_AM;
      ch_q       <= CH_FM;
      soc_q      <= 1'b0;
      fm_valid_q <= 1'b0;
      am_valid_q <= 1'b0;
      fm_data_q  <= '0;
      am_data_q  <= '0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      soc_q      <= 1'b0;
      fm_valid_q <= 1'b0;
      am_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
      if (slot_tick && state_q != IDLE) overrun_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (slot_tick) begin
            state_q   <= SOC;
            soc_q     <= 1'b1;
            ch_q      <= grant;
            last_ch_q <= grant;
          end
        end
        SOC: begin
          to_cnt_q <= '0;
          state_q  <= WAIT_EOC;
        end
        WAIT_EOC: begin
          if (eoc_rise) begin
            if (fm_take) begin
              fm_data_q  <= ADC_DATA;
              fm_valid_q <= 1'b1;
            end
            if (am_take) begin
              am_data_q  <= ADC_DATA;
              am_valid_q <= 1'b1;
            end
            state_q <= CAPTURE;
          end else if (to_cnt_inc == TO_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_inc;
          end
        end
        CAPTURE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  sample_decimator #(
    .BPS_PARA(BPS_PARA)
  ) u_fm_dec (
    .clk_i         (CLK),
    .rst_n_i       (RSTn),
    .enable_i      (FM_demod_en),
    .sample_valid_i(fm_take),
    .strobe_o      (clk_fm_demo_sampling)
  );

  assign ADC_SOC         = soc_q;
  assign ADC_CH          = ch_q;
  assign fm_sample_valid = fm_valid_q;
  assign fm_sample_data  = fm_data_q;
  assign am_sample_valid = am_valid_q;
  assign am_sample_data  = am_data_q;
  assign overrun         = overrun_q;
  assign timeout_err     = timeout_q;

endmodule
